// File: rtl/encoder_pkg.sv
// Shared encodings for the rotary-encoder front end: AB Gray states,
// decoded transition kinds, decoder FSM states and the default debounce depth.
// Pure declarations; no timing or flow control of its own.
package encoder_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;

  // Quadrature states listed in clockwise order.
  typedef enum logic [1:0] {
    AB_00 = 2'b00,
    AB_01 = 2'b01,
    AB_11 = 2'b11,
    AB_10 = 2'b10
  } ab_t;

  typedef enum logic [1:0] {
    TR_NONE,
    TR_UP,
    TR_DN,
    TR_ILLEGAL
  } trans_t;

  typedef enum logic {
    SETTLE,
    RUN
  } fsm_t;

  // Map a Gray-coded AB pair to its position in the clockwise cycle.
  function automatic logic [1:0] ab_to_pos(logic [1:0] ab);
    logic [1:0] pos;
    case (ab)
      AB_00:   pos = 2'd0;
      AB_01:   pos = 2'd1;
      AB_11:   pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return pos;
  endfunction

  // Position difference modulo 4: +1 is clockwise, -1 (3) is counter-clockwise,
  // 2 means both channels moved at once and the direction is unknowable.
  function automatic trans_t classify(logic [1:0] prev, logic [1:0] cur);
    logic [1:0] d;
    trans_t     t;
    d = ab_to_pos(cur) - ab_to_pos(prev);
    case (d)
      2'd0:    t = TR_NONE;
      2'd1:    t = TR_UP;
      2'd3:    t = TR_DN;
      default: t = TR_ILLEGAL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser plus debounce counter for one raw encoder contact.
// Latency: stable follows a held input DEBOUNCE_CYCLES+1 edges after s1 captures it.
// No backpressure; free-running every clock.
// Ports: clk, reset (async, active-high), raw (asynchronous contact), stable (debounced level).
module debounce
  import encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any cycle where s2 agrees with stable restarts the run, so only an
      // uninterrupted run of DEBOUNCE_CYCLES disagreeing cycles is accepted.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Debounces A/B encoder contacts and decodes Gray transitions into a 2-bit wrapping count.
// Latency: count and step pulse update DEBOUNCE_CYCLES+2 edges after s1 captures a new level.
// No backpressure; at most one +/-1 step per clock, illegal double moves flagged via error.
// Ports: clk, reset (async, active-high), enc_a/enc_b (raw contacts),
//        encoder_value (mod-4 count), step_up/step_dn/error (one-cycle registered pulses).
module quadrature_decoder
  import encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic [1:0] encoder_value,
  output logic       step_up,
  output logic       step_dn,
  output logic       error
);

  // SETTLE must still own prev on the edge after the debouncers can first
  // present a reset-time resting level, otherwise a 11 rest would look like
  // an illegal 00->11 jump. Count 0..DEBOUNCE_CYCLES+2 before entering RUN.
  localparam int SETTLE_LAST = DEBOUNCE_CYCLES + 2;
  localparam int SW          = $clog2(SETTLE_LAST + 1);
  localparam logic [SW-1:0] SETTLE_LAST_V = SW'(SETTLE_LAST);

  logic          stable_a;
  logic          stable_b;
  logic [1:0]    cur;
  logic [1:0]    prev;
  trans_t        trans;

  fsm_t          state_q;
  fsm_t          state_d;
  logic [SW-1:0] settle_q;
  logic [SW-1:0] settle_d;
  logic [1:0]    value_d;
  logic          up_d;
  logic          dn_d;
  logic          err_d;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk    (clk),
    .reset  (reset),
    .raw    (enc_a),
    .stable (stable_a)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk    (clk),
    .reset  (reset),
    .raw    (enc_b),
    .stable (stable_b)
  );

  assign cur   = {stable_a, stable_b};
  assign trans = classify(prev, cur);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    value_d  = encoder_value;
    up_d     = 1'b0;
    dn_d     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      SETTLE: begin
        if (settle_q == SETTLE_LAST_V) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      RUN: begin
        case (trans)
          TR_UP: begin
            value_d = encoder_value + 2'd1;
            up_d    = 1'b1;
          end
          TR_DN: begin
            value_d = encoder_value - 2'd1;
            dn_d    = 1'b1;
          end
          TR_ILLEGAL: err_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SETTLE;
      settle_q      <= '0;
      prev          <= 2'b00;
      encoder_value <= 2'b00;
      step_up       <= 1'b0;
      step_dn       <= 1'b0;
      error         <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      // prev tracks cur unconditionally: in SETTLE to absorb the flush, in RUN
      // so that an illegal jump is reported once rather than every cycle.
      prev          <= cur;
      encoder_value <= value_d;
      step_up       <= up_d;
      step_dn       <= dn_d;
      error         <= err_d;
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder with DEBOUNCE_CYCLES=4.
// Table of clean AB moves with hand-computed counts, plus directed
// sequences for settle, bounce rejection and reset mid-debounce.
module tb_quadrature_decoder;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_a;
  logic       enc_b;
  logic [1:0] encoder_value;
  logic       step_up;
  logic       step_dn;
  logic       error;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       a;
    logic       b;
    logic [1:0] val;
    logic       up;
    logic       dn;
    logic       err;
  } vec_t;

  vec_t vecs[12];

  quadrature_decoder #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk           (clk),
    .reset         (reset),
    .enc_a         (enc_a),
    .enc_b         (enc_b),
    .encoder_value (encoder_value),
    .step_up       (step_up),
    .step_dn       (step_dn),
    .error         (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_prev;
    int         ups;
    int         dns;
    int         errs;
    int         val_changes;

    //           a     b     val    up    dn    err
    vecs[0]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0}; // 00->01 cw
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0}; // 01->11 cw
    vecs[2]  = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0}; // 11->10 cw
    vecs[3]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0}; // 10->00 cw, count wraps
    vecs[4]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0}; // 00->10 ccw, wraps down
    vecs[5]  = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0}; // 10->11 ccw
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0}; // 11->01 ccw
    vecs[7]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0}; // 01->00 ccw
    vecs[8]  = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1}; // 00->11 illegal
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0}; // 11->10 cw after illegal
    vecs[10] = '{1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0}; // 10->00 cw
    vecs[11] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0}; // 00->01 from... ccw? no: see below

    // 00->01 is clockwise; fix the last entry to reach AB=01 with the right count.
    vecs[11] = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0};

    // Reset state, inputs resting at 11 across reset release.
    reset = 1'b1;
    enc_a = 1'b1;
    enc_b = 1'b1;
    #12;
    chk("reset_value",   encoder_value, 2'b00);
    chk("reset_step_up", step_up, 1'b0);
    chk("reset_step_dn", step_dn, 1'b0);
    chk("reset_error",   error,   1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 3 * DB + 8; c++) begin
      tick(1);
      chk("settle11_value", encoder_value, 2'b00);
      chk("settle11_error", error, 1'b0);
      chk("settle11_steps", {step_up, step_dn}, 2'b00);
    end

    // Restart with the encoder resting at 00 for the move table.
    reset = 1'b1;
    enc_a = 1'b0;
    enc_b = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(3 * DB);

    exp_prev = 2'b00;
    for (int i = 0; i < 12; i++) begin
      enc_a = vecs[i].a;
      enc_b = vecs[i].b;
      // Next edge is s1 capture (edge 0); edges 0..DB+1 must show no change.
      tick(DB + 2);
      chk("early_value", encoder_value, exp_prev);
      chk("early_steps", {step_up, step_dn, error}, 3'b000);
      tick(1);
      chk("step_value",   encoder_value, vecs[i].val);
      chk("step_step_up", step_up, vecs[i].up);
      chk("step_step_dn", step_dn, vecs[i].dn);
      chk("step_error",   error,   vecs[i].err);
      tick(1);
      chk("after_value", encoder_value, vecs[i].val);
      chk("after_pulses_clear", {step_up, step_dn, error}, 3'b000);
      exp_prev = vecs[i].val;
    end

    // Bounce on A (AB=01, count 11): runs of at most 2 cycles never pass.
    ups = 0; dns = 0; errs = 0; val_changes = 0;
    for (int c = 0; c < 30; c++) begin
      enc_a = (c % 3 != 2);
      tick(1);
      ups  += int'(step_up);
      dns  += int'(step_dn);
      errs += int'(error);
      if (encoder_value !== 2'b11) val_changes++;
    end
    chk("bounce_no_up",      ups,  0);
    chk("bounce_no_dn",      dns,  0);
    chk("bounce_no_err",     errs, 0);
    chk("bounce_val_steady", val_changes, 0);
    enc_a = 1'b1;
    ups = 0; dns = 0; errs = 0;
    for (int c = 0; c < 3 * DB; c++) begin
      tick(1);
      ups  += int'(step_up);
      dns  += int'(step_dn);
      errs += int'(error);
    end
    chk("bounce_one_up",  ups,  1);
    chk("bounce_hold_dn", dns,  0);
    chk("bounce_hold_err", errs, 0);
    chk("bounce_value",   encoder_value, 2'b00);

    // Reset while A's debounce counter sits at 2 (AB moving 11->01).
    enc_a = 1'b0;
    tick(4);
    reset = 1'b1;
    #1;
    chk("midrst_value",  encoder_value, 2'b00);
    chk("midrst_pulses", {step_up, step_dn, error}, 3'b000);
    tick(2);
    reset = 1'b0;
    ups = 0; dns = 0; errs = 0; val_changes = 0;
    for (int c = 0; c < 3 * DB + 8; c++) begin
      tick(1);
      ups  += int'(step_up);
      dns  += int'(step_dn);
      errs += int'(error);
      if (encoder_value !== 2'b00) val_changes++;
    end
    chk("midrst_no_up",  ups,  0);
    chk("midrst_no_dn",  dns,  0);
    chk("midrst_no_err", errs, 0);
    chk("midrst_value_held", val_changes, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
# quadrature_decoder

Front-end stage for the rotary encoder input. It synchronises and debounces the raw, asynchronous A/B quadrature contacts and decodes valid Gray-code transitions. It drives a 2-bit wrapping position counter, `encoder_value`, which the paddle stage differences cycle-by-cycle to move the paddle. It guarantees at most one ±1 step per clock, suppresses contact bounce, and flags illegal double transitions instead of counting them.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: consecutive clocks a synchronised input must differ from its debounced value before the debounced value changes. Legal range ≥ 1.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high; clock `clk`.
- `enc_a`  in  1: raw encoder channel A, asynchronous to `clk`.
- `enc_b`  in  1: raw encoder channel B, asynchronous to `clk`.
- `encoder_value`  out  2: wrapping position count, two's-complement arithmetic modulo 4.
- `step_up`  out  1: one-cycle pulse, asserted in the cycle `encoder_value` incremented.
- `step_dn`  out  1: one-cycle pulse, asserted in the cycle `encoder_value` decremented.
- `error`  out  1: one-cycle pulse on an illegal transition (both channels changed in the same cycle) while in RUN.

## Operation
- **Synchroniser:** two flops per channel, s1 then s2. Both reset to 0.
- **Debouncer, per channel:** a counter of width clog2(DEBOUNCE_CYCLES+1) and a `stable` bit. On each edge:
  - If s2 == `stable`: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES−1: `stable` ← s2 and counter ← 0.
  - Else: counter ← counter + 1.
  - The two channels are fully independent.
- **Decoder** compares `cur` = {stable_a, stable_b} with the registered `prev`.
  - Increment on 00→01, 01→11, 11→10, 10→00.
  - Decrement on the reverse of each of those transitions.
  - Both bits differing (00↔11, 01↔10) is illegal. Pulse `error`, leave the count unchanged, set `prev` ← `cur`.
  - `cur` == `prev`: no action.
- **Count arithmetic:** `encoder_value` wraps 11→00 on increment and 00→11 on decrement. No saturation.
- **FSM:**
  - SETTLE: entered on reset. `prev` ← `cur` every cycle. No steps, no errors. A settle counter runs for DEBOUNCE_CYCLES+2 cycles, then the FSM moves to RUN. This absorbs the post-reset flush of the synchroniser and debouncer, so an encoder resting at 11 produces no spurious error.
  - RUN: decoding active. It leaves RUN only on reset.
- Reset mid-operation returns everything to reset values immediately. Any in-progress debounce count is discarded.

## Timing
- **Reset values:** `encoder_value`=00, `step_up`=0, `step_dn`=0, `error`=0. s1, s2, `stable` and all counters are 0. `prev`=00. FSM is in SETTLE.
- **Latency:** call edge 0 the edge at which s1 first captures a new level. If that level is held:
  - `stable` updates at edge DEBOUNCE_CYCLES+1.
  - `encoder_value` and the step pulse update at edge DEBOUNCE_CYCLES+2.
- Bounce shorter than DEBOUNCE_CYCLES cycles never reaches `stable`.
- Pulses are registered and last exactly one cycle. They coincide with the cycle in which `encoder_value` holds its new value.
- `encoder_value` changes by at most ±1 per cycle. The downstream 2-bit difference is therefore always 01, 11 or 00.
- **Simultaneous `stable` updates on both channels:** illegal transition → `error`, no count change.

## Structure
- Shared package `encoder_pkg`:
  - The 2-bit state/transition encodings.
  - The FSM state type {SETTLE, RUN}.
  - The default-debounce constant.
- Sub-module `debounce`: synchroniser, counter and `stable` bit for one channel, parameterised by DEBOUNCE_CYCLES. It is instantiated twice.
- The decoder and FSM live in `quadrature_decoder`.

## Test plan
- **Reset / settle:** DEBOUNCE_CYCLES=4, enc_a=enc_b=1 held through reset release → `encoder_value`=00 and `error`=0 for all cycles, including after SETTLE ends.
- **Clockwise step:** in RUN with AB=00, drive AB=01 (clean) → `encoder_value` 00→01 and `step_up` high for one cycle, exactly DEBOUNCE_CYCLES+2 edges after s1 capture. Four clockwise steps → 01,10,11,00 (wrap).
- **Counter-clockwise step:** from AB=00, drive AB=10 → `encoder_value` 00→11, `step_dn` one cycle.
- **Bounce rejection:** DEBOUNCE_CYCLES=4, toggle enc_a with a period of 3 cycles for 30 cycles, then hold at 1 → exactly one `step_up`. No counts during the toggling.
- **Illegal transition:** AB 00→11 with both edges on the same cycle → `error` one cycle, `encoder_value` unchanged. The next legal 11→10 → `step_up`.
- **Reset mid-debounce:** assert `reset` while a channel's counter is at 2 → all outputs 0 immediately. After release the FSM re-enters SETTLE and no step is emitted for the aborted edge.
